wb_commit_unit: RTL

// - Writeback stage: consumes the WB_* outputs of the MEM/WB pipeline register.
// - Selects the result, then commits scalar writes to the scalar regfile.
// - Gathers 32-bit vector beats into 128-bit words for the vector regfile.
// - Provides a forwarding tap for EX-stage hazard resolution.

---
 rtl/wb_commit_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback stage commit logic.
// Selects the writeback result and registers scalar writes to the scalar
// regfile. Gathers LANES 32-bit vector beats into one wide word for the
// vector regfile, and drives a combinational forwarding tap for EX hazards.
// Optional build macro: VLANE_TIMEOUT_EN. When defined, a partial vector
// word is dropped after VTMO idle cycles in FILL.
//
// state | meaning
// IDLE  | no partial vector word staged
// FILL  | 1..LANES-1 lanes staged for vector register 'tag'
module wb_commit_unit #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int LANES  = 4,
    parameter int VTMO   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       WB_MemData,
    input  logic [DATA_W-1:0]       WB_ALUResult,
    input  logic [DATA_W-1:0]       WB_sbox,
    input  logic [RD_W-1:0]         WB_rd,
    input  logic [1:0]              WB_MemToReg,
    input  logic                    WB_RegWrite,
    input  logic                    WB_VRegWrite,
    output logic                    rf_we,
    output logic [RD_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]       rf_wdata,
    output logic                    vrf_we,
    output logic [RD_W-1:0]         vrf_waddr,
    output logic [LANES*DATA_W-1:0] vrf_wdata,
    output logic                    fwd_valid,
    output logic [RD_W-1:0]         fwd_rd,
    output logic [DATA_W-1:0]       fwd_data,
    output logic                    vlane_err
);

    localparam int VEC_W = LANES * DATA_W;
    // lane_cnt never holds LANES: the LANES-th beat commits and wraps to 0
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    lane_cnt;
    logic [DATA_W-1:0]   lanes [LANES];
    logic [RD_W-1:0]     tag;

    logic [DATA_W-1:0]   res;
    logic                scalar_ok;
    logic                conflict;
    logic                last_beat;
    logic                tag_drop;
    logic [VEC_W-1:0]    word_full;

`ifdef VLANE_TIMEOUT_EN
    localparam int TMO_W = $clog2(VTMO + 1);
    logic [TMO_W-1:0]    idle_cnt;
`endif

    // Result select; the reserved code 11 falls back to the ALU result
    always_comb begin
        res = WB_ALUResult;
        case (WB_MemToReg)
            2'b01:   res = WB_MemData;
            2'b10:   res = WB_sbox;
            default: res = WB_ALUResult;
        endcase
    end

    assign scalar_ok = WB_RegWrite && !WB_VRegWrite && (WB_rd != '0);
    assign conflict  = WB_RegWrite && WB_VRegWrite;

    // In IDLE lane_cnt is 0, so this only fires from IDLE when LANES==1
    assign last_beat = WB_VRegWrite && (lane_cnt == CNT_W'(LANES - 1)) &&
                       ((state == IDLE) || (WB_rd == tag));
    assign tag_drop  = WB_VRegWrite && (state == FILL) && (WB_rd != tag);

    assign fwd_valid = scalar_ok;
    assign fwd_rd    = WB_rd;
    assign fwd_data  = res;

    // Full vector word as it would look with the current beat merged in
    always_comb begin
        word_full = '0;
        for (int i = 0; i < LANES; i++) begin
            word_full[i*DATA_W +: DATA_W] = (lane_cnt == CNT_W'(i)) ? res : lanes[i];
        end
    end

    // Scalar regfile write port; address/data hold when no write is issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= scalar_ok;
            if (scalar_ok) begin
                rf_waddr <= WB_rd;
                rf_wdata <= res;
            end
        end
    end

    // Vector lane gathering FSM with registered commit and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lane_cnt  <= '0;
            tag       <= '0;
            vrf_we    <= 1'b0;
            vrf_waddr <= '0;
            vrf_wdata <= '0;
            vlane_err <= 1'b0;
            for (int i = 0; i < LANES; i++) lanes[i] <= '0;
`ifdef VLANE_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else begin
            vrf_we    <= 1'b0;
            vlane_err <= conflict;
            if (WB_VRegWrite) begin
`ifdef VLANE_TIMEOUT_EN
                idle_cnt <= '0;
`endif
                if (last_beat) begin
                    vrf_we    <= 1'b1;
                    vrf_waddr <= WB_rd;
                    vrf_wdata <= word_full;
                    state     <= IDLE;
                    lane_cnt  <= '0;
                    for (int i = 0; i < LANES; i++) lanes[i] <= '0;
                end else if ((state == IDLE) || tag_drop) begin
                    // A tag change discards the partial word and restarts the fill
                    if (tag_drop) vlane_err <= 1'b1;
                    for (int i = 0; i < LANES; i++) lanes[i] <= '0;
                    lanes[0] <= res;
                    tag      <= WB_rd;
                    lane_cnt <= CNT_W'(1);
                    state    <= FILL;
                end else begin
                    lanes[lane_cnt] <= res;
                    lane_cnt        <= lane_cnt + CNT_W'(1);
                end
            end
`ifdef VLANE_TIMEOUT_EN
            else if (state == FILL) begin
                if (idle_cnt == TMO_W'(VTMO - 1)) begin
                    vlane_err <= 1'b1;
                    state     <= IDLE;
                    lane_cnt  <= '0;
                    idle_cnt  <= '0;
                    for (int i = 0; i < LANES; i++) lanes[i] <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TMO_W'(1);
                end
            end
`endif
        end
    end

endmodule
